// File: rtl/req_scan_arbiter_64_pkg.sv
// Shared definitions for the 64-requester scanning arbiter: state codes,
// pointer and hold-counter widths, and the pointer increment helper.
package req_scan_arbiter_64_pkg;

    localparam int NUM_REQ = 64;
    localparam int PTR_W   = 6;
    localparam int HOLD_W  = 8;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_SCAN  = 2'd1;
    localparam logic [1:0] ARB_GRANT = 2'd2;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [HOLD_W-1:0] hold_t;

    // Pointer width equals log2(NUM_REQ), so plain overflow gives the 63 -> 0 wrap.
    function automatic ptr_t ptr_next(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/req_scan_arbiter_64_if.sv
// Request/grant bundle between the shared-resource fabric (master) and the
// scanning arbiter (slave).
interface req_scan_arbiter_64_if;
    import req_scan_arbiter_64_pkg::*;

    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic               done;
    ptr_t               scan_select;
    logic               grant_valid;
    ptr_t               grant_id;
    logic               busy;
    logic               timeout;

    modport master (
        output enable, req, done,
        input  scan_select, grant_valid, grant_id, busy, timeout
    );

    modport slave (
        input  enable, req, done,
        output scan_select, grant_valid, grant_id, busy, timeout
    );

endinterface

// File: rtl/req_scan_arbiter_64_mux_64_1_bit.sv
// 64:1 single-bit mux: returns the request bit addressed by the scan pointer.
module mux_64_1_bit
    import req_scan_arbiter_64_pkg::*;
(
    input  ptr_t               select,
    input  logic [NUM_REQ-1:0] in_bits,
    output logic               hit
);

    assign hit = in_bits[select];

endmodule

// File: rtl/req_scan_arbiter_64.sv
// Round-robin arbiter that walks a pointer across 64 request lines and holds
// the first hit until the owner signals done or the hold timer expires.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | parked, pointer frozen, waiting for enable
// ARB_SCAN  | one request bit tested per cycle, pointer advances on miss
// ARB_GRANT | grant held for grant_id until done or hold timeout
// (code 3)  | illegal, falls back to ARB_IDLE on the next edge
module req_scan_arbiter_64
    import req_scan_arbiter_64_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic                  clock,
    input  logic                  reset,
    req_scan_arbiter_64_if.slave  bus
);

    localparam bit    HOLD_EN   = (TIMEOUT != 0);
    localparam hold_t HOLD_LAST = (TIMEOUT == 0) ? hold_t'(0) : hold_t'(TIMEOUT - 1);

    logic [1:0] state;
    ptr_t       ptr;
    ptr_t       grant_id;
    hold_t      hold_cnt;
    logic       timeout_q;
    logic       hit;
    logic       hold_expire;
    logic       release_now;

    mux_64_1_bit u_mux (
        .select  (ptr),
        .in_bits (bus.req),
        .hit     (hit)
    );

    assign hold_expire = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || hold_expire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (bus.enable) begin
                        state <= ARB_SCAN;
                    end
                end
                ARB_SCAN: begin
                    // Dropping enable wins over a hit in the same cycle.
                    if (!bus.enable) begin
                        state <= ARB_IDLE;
                    end else if (hit) begin
                        state    <= ARB_GRANT;
                        grant_id <= ptr;
                        hold_cnt <= '0;
                    end else begin
                        ptr <= ptr_next(ptr);
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        ptr       <= ptr_next(grant_id);
                        state     <= bus.enable ? ARB_SCAN : ARB_IDLE;
                        // A done in the expiry cycle counts as a normal release.
                        timeout_q <= !bus.done;
                    end else begin
                        hold_cnt <= hold_cnt + hold_t'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.scan_select = ptr;
    assign bus.grant_valid = (state == ARB_GRANT);
    assign bus.busy        = (state != ARB_IDLE);
    assign bus.grant_id    = grant_id;
    assign bus.timeout     = timeout_q;

endmodule
